// File: rtl/cam_dvp_capture.sv
// DVP pixel capture: waits for camera configuration, skips start-up frames, then
// assembles RGB565 pixels with frame/line markers. Optional statistics: CAM_CAP_STATS_EN.
module cam_dvp_capture #(
    parameter int H_ACTIVE       = 800,
    parameter int V_ACTIVE       = 480,
    parameter int SKIP_FRAMES    = 10,
    parameter bit VS_ACTIVE_HIGH = 1'b1
) (
    input  logic        clk_pclk,
    input  logic        rst_100,
    input  logic        cfg_done,
    input  logic        cap_en,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_done,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        size_err
);

    localparam int         SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [9:0] X_MAX  = 10'(H_ACTIVE);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_MAX  = 9'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_ARM,
        ST_CAPTURE
    } state_t;

    state_t            state, state_n;
    logic [1:0]        cfg_sync;
    logic              cfg_s;
    logic              vs_r, hr_r, hr_d, vs_act, vs_act_d;
    logic [7:0]        d_r;
    logic [SKIP_W-1:0] skip_cnt;
    logic              skip_load, skip_dec, frame_start, frame_end;
    logic              start_edge, end_edge, hr_fall;
    logic              in_cap, capturing, assemble, in_range, emit, line_end;
    logic              phase, line_has_byte;
    logic [7:0]        hi_byte;
    logic [9:0]        x_cnt;
    logic [8:0]        y_cnt;

    assign cfg_s      = cfg_sync[1];
    assign vs_act     = VS_ACTIVE_HIGH ? vs_r : ~vs_r;
    assign start_edge = vs_act_d & ~vs_act;
    assign end_edge   = ~vs_act_d & vs_act;
    assign hr_fall    = hr_d & ~hr_r;

    // A frame-end edge, or losing cfg_done, aborts whatever pixel is in flight.
    assign in_cap    = (state == ST_CAPTURE) && cfg_s;
    assign capturing = in_cap && !end_edge;
    assign assemble  = capturing && hr_r && phase;
    assign in_range  = (x_cnt < X_MAX) && (y_cnt < Y_MAX);
    assign emit      = assemble && in_range;
    assign line_end  = in_cap && hr_fall;
    assign busy      = (state == ST_CAPTURE);

    // NOTE: registers update with non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_pclk or negedge rst_100) begin
        if (!rst_100) begin
            cfg_sync <= '0;
            vs_r     <= 1'b0;
            hr_r     <= 1'b0;
            hr_d     <= 1'b0;
            d_r      <= '0;
            vs_act_d <= 1'b0;
        end else begin
            cfg_sync <= {cfg_sync[0], cfg_done};
            vs_r     <= cam_vsync;
            hr_r     <= cam_href;
            hr_d     <= hr_r;
            d_r      <= cam_data;
            vs_act_d <= vs_act;
        end
    end

    always_ff @(posedge clk_pclk or negedge rst_100) begin
        if (!rst_100) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
        end else begin
            state <= state_n;
            if (skip_load) begin
                skip_cnt <= SKIP_W'(SKIP_FRAMES);
            end else if (skip_dec) begin
                skip_cnt <= skip_cnt - 1'b1;
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_n     = state;
        skip_load   = 1'b0;
        skip_dec    = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        if (!cfg_s) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_n   = ST_SKIP;
                    skip_load = 1'b1;
                end
                ST_SKIP: begin
                    if (start_edge) begin
                        if (skip_cnt != '0) begin
                            skip_dec = 1'b1;
                        end else if (cap_en) begin
                            state_n     = ST_CAPTURE;
                            frame_start = 1'b1;
                        end else begin
                            state_n = ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (start_edge && cap_en) begin
                        state_n     = ST_CAPTURE;
                        frame_start = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (end_edge) begin
                        state_n   = ST_ARM;
                        frame_end = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pclk or negedge rst_100) begin
        if (!rst_100) begin
            phase         <= 1'b0;
            line_has_byte <= 1'b0;
            hi_byte       <= '0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            pix_data      <= '0;
            pix_valid     <= 1'b0;
            pix_sof       <= 1'b0;
            pix_eol       <= 1'b0;
            pix_x         <= '0;
            pix_y         <= '0;
            frame_done    <= 1'b0;
        end else begin
            phase <= (capturing && hr_r) ? ~phase : 1'b0;
            if (capturing && hr_r && !phase) begin
                hi_byte <= d_r;
            end

            if (!hr_r) begin
                line_has_byte <= 1'b0;
            end else if (capturing) begin
                line_has_byte <= 1'b1;
            end

            // Counters saturate at the active size so overflow stays detectable.
            if (frame_start || hr_fall) begin
                x_cnt <= '0;
            end else if (assemble && (x_cnt < X_MAX)) begin
                x_cnt <= x_cnt + 1'b1;
            end

            if (frame_start) begin
                y_cnt <= '0;
            end else if (line_end && line_has_byte && (y_cnt < Y_MAX)) begin
                y_cnt <= y_cnt + 1'b1;
            end

            pix_valid <= emit;
            pix_sof   <= emit && (x_cnt == '0) && (y_cnt == '0);
            pix_eol   <= emit && (x_cnt == X_LAST);
            if (emit) begin
                pix_data <= {hi_byte, d_r};
                pix_x    <= x_cnt;
                pix_y    <= y_cnt;
            end

            frame_done <= frame_end;
        end
    end

`ifdef CAM_CAP_STATS_EN
    logic err_any;

    // Odd byte count, overflow, short line/frame, or vsync edge during href.
    assign err_any = (assemble && !in_range)
                   || (line_end && phase)
                   || (line_end && line_has_byte && (x_cnt < X_MAX))
                   || (in_cap && end_edge && (hr_r || (y_cnt < Y_MAX)));

    always_ff @(posedge clk_pclk or negedge rst_100) begin
        if (!rst_100) begin
            frame_cnt <= '0;
            size_err  <= 1'b0;
        end else begin
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (err_any) begin
                size_err <= 1'b1;
            end
        end
    end
`else
    assign frame_cnt = '0;
    assign size_err  = 1'b0;
`endif

endmodule

// File: tb/tb_cam_dvp_capture.sv
// Bench for cam_dvp_capture on a 4x2 geometry: directed frames plus random frames,
// scored against a frame-level model of skip, capture, pixel and error rules.
module tb_cam_dvp_capture;

    localparam int H    = 4;
    localparam int V    = 2;
    localparam int SKIP = 2;
`ifdef CAM_CAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk_pclk = 1'b0;
    logic        rst_100 = 1'b0;
    logic        cfg_done = 1'b0;
    logic        cap_en = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic [15:0] pix_data;
    logic        pix_valid, pix_sof, pix_eol;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        frame_done, busy, size_err;
    logic [15:0] frame_cnt;

    always #5 clk_pclk = ~clk_pclk;

    cam_dvp_capture #(
        .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(SKIP), .VS_ACTIVE_HIGH(1'b1)
    ) dut (
        .clk_pclk(clk_pclk), .rst_100(rst_100), .cfg_done(cfg_done), .cap_en(cap_en),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done), .busy(busy),
        .frame_cnt(frame_cnt), .size_err(size_err)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic        eol;
    } pix_t;

    pix_t exp_q[$];
    pix_t obs_q[$];
    int   obs_cyc_q[$];
    int   cyc = 0;
    int   done_obs = 0;
    int   stray = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    // Reference model state
    int         skip_left;
    bit         prev_cap, cur_cap, exp_err;
    int         exp_done = 0;
    int         exp_fcnt = 0;
    logic [7:0] fb [0:63];
    int         ll [0:7];
    int         nl;
    int         first_b1_cyc, first_pix_cyc;

    always @(posedge clk_pclk) cyc <= cyc + 1;

    initial forever begin
        pix_t p;
        @(posedge clk_pclk);
        #1;
        if (pix_valid) begin
            p.d = pix_data; p.x = pix_x; p.y = pix_y; p.sof = pix_sof; p.eol = pix_eol;
            obs_q.push_back(p);
            obs_cyc_q.push_back(cyc);
        end
        if (frame_done) done_obs++;
        if ((pix_sof || pix_eol) && !pix_valid) stray++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] out_vec();
        return {7'd0, pix_data, pix_valid, pix_sof, pix_eol, pix_x, pix_y,
                frame_done, busy, frame_cnt, size_err};
    endfunction

    // Pixels a captured frame should yield, and whether it breaks the geometry rules.
    function automatic void build_expected(input bit malformed);
        int   off = 0;
        int   y = 0;
        int   lines;
        pix_t e;
        lines = malformed ? nl - 1 : nl;
        for (int l = 0; l < lines; l++) begin
            if (ll[l] > 0) begin
                for (int p = 0; p < ll[l] / 2; p++) begin
                    if (p < H && y < V) begin
                        e.d   = {fb[off + 2*p], fb[off + 2*p + 1]};
                        e.x   = 10'(p);
                        e.y   = 9'(y);
                        e.sof = (p == 0) && (y == 0);
                        e.eol = (p == H - 1);
                        exp_q.push_back(e);
                    end else begin
                        exp_err = 1'b1;
                    end
                end
                if ((ll[l] % 2) != 0 || (ll[l] / 2) < H) exp_err = 1'b1;
                y++;
            end
            off += ll[l];
        end
        if (malformed || y < V) exp_err = 1'b1;
    endfunction

    task automatic check_status(input string tag);
        check({tag, "_done"}, done_obs, exp_done);
        check({tag, "_fcnt"}, frame_cnt, STATS ? 16'(exp_fcnt) : 16'd0);
        check({tag, "_serr"}, size_err, STATS ? exp_err : 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic end_pulse();
        @(negedge clk_pclk);
        if (!cam_vsync && prev_cap) begin
            exp_done++;
            exp_fcnt++;
        end
        prev_cap  = 1'b0;
        cam_vsync = 1'b1;
        repeat (4) @(negedge clk_pclk);
        check_status("end");
    endtask

    task automatic frame_begin(input bit cap, input bit malformed);
        end_pulse();
        cap_en    = cap;
        cam_vsync = 1'b0;
        if (skip_left > 0) begin
            skip_left--;
            cur_cap = 1'b0;
        end else begin
            cur_cap = cap;
        end
        if (cur_cap) build_expected(malformed);
        repeat (4) @(negedge clk_pclk);
    endtask

    task automatic drive_line(input int off, input int n, input bit first, input bit mal_last);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_pclk);
            cam_href = 1'b1;
            cam_data = fb[off + i];
            if (first && i == 1) first_b1_cyc = cyc;
            if (mal_last && i == n - 1) cam_vsync = 1'b1;
        end
        @(negedge clk_pclk);
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (3) @(negedge clk_pclk);
    endtask

    task automatic compare_pixels();
        int n;
        check("npix", obs_q.size(), exp_q.size());
        first_pix_cyc = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : -1;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check($sformatf("pix%0d", i), obs_q[i], exp_q[i]);
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic frame_body(input bit cap_mid, input bit malformed);
        int off = 0;
        for (int l = 0; l < nl; l++) begin
            drive_line(off, ll[l], l == 0, malformed && (l == nl - 1));
            off += ll[l];
            if (l == 0) begin
                check("busy_mid", busy, cur_cap);
                if (cap_mid) cap_en = 1'b1;
            end
        end
        repeat (4) @(negedge clk_pclk);
        compare_pixels();
        if (malformed) begin
            if (cur_cap) begin
                exp_done++;
                exp_fcnt++;
            end
        end else begin
            prev_cap = cur_cap;
        end
    endtask

    task automatic fill_full();
        nl = 2;
        ll[0] = 2 * H;
        ll[1] = 2 * H;
        for (int i = 0; i < 4 * H; i++) fb[i] = 8'($urandom);
    endtask

    task automatic fill_lines(input int a, input int b);
        nl = 2;
        ll[0] = a;
        ll[1] = b;
        for (int i = 0; i < a + b; i++) fb[i] = 8'($urandom);
    endtask

    task automatic run_frame(input bit cap, input bit cap_mid, input bit malformed);
        frame_begin(cap, malformed);
        frame_body(cap_mid, malformed);
    endtask

    initial begin
        bit cap, mid, mal;
        skip_left = SKIP;
        prev_cap  = 1'b0;
        cur_cap   = 1'b0;
        exp_err   = 1'b0;

        repeat (3) @(negedge clk_pclk);
        check("reset_outputs", out_vec(), 64'd0);
        rst_100  = 1'b1;
        cfg_done = 1'b1;
        repeat (10) @(negedge clk_pclk);

        // Two skipped frames, then two captured; frame 3 starts with red, green.
        for (int f = 0; f < 4; f++) begin
            fill_full();
            if (f == 2) begin
                fb[0] = 8'hF8; fb[1] = 8'h00; fb[2] = 8'h07; fb[3] = 8'hE0;
            end
            run_frame(1'b1, 1'b0, 1'b0);
            if (f == 2) check("latency", first_pix_cyc, first_b1_cyc + 2);
        end

        fill_lines(2 * H + 2, 2 * H);          // one line too long
        run_frame(1'b1, 1'b0, 1'b0);
        fill_lines(7, 2 * H);                  // odd byte count
        run_frame(1'b1, 1'b0, 1'b0);
        fill_full();
        run_frame(1'b1, 1'b0, 1'b0);

        fill_full();                           // not permitted at start, raised mid-frame
        run_frame(1'b0, 1'b1, 1'b0);
        fill_full();
        run_frame(1'b1, 1'b0, 1'b0);

        fill_lines(2 * H, 2);                  // vsync rises on a second byte
        run_frame(1'b1, 1'b0, 1'b1);
        fill_full();
        run_frame(1'b1, 1'b0, 1'b0);

        for (int f = 0; f < 20; f++) begin
            if ($urandom_range(0, 1) == 0) begin
                fill_full();
            end else begin
                nl = $urandom_range(1, 3);
                for (int l = 0; l < nl; l++) ll[l] = $urandom_range(1, 11);
                for (int i = 0; i < 40; i++) fb[i] = 8'($urandom);
            end
            cap = ($urandom_range(0, 3) != 0);
            mid = !cap && ($urandom_range(0, 1) == 0);
            mal = (nl >= 2) && ($urandom_range(0, 7) == 0);
            if (mal) ll[nl - 1] = 2;
            run_frame(cap, mid, mal);
        end

        // Reset in the middle of a captured line, then re-skip.
        fill_full();
        frame_begin(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_pclk);
            cam_href = 1'b1;
            cam_data = fb[i];
        end
        @(negedge clk_pclk);
        rst_100 = 1'b0;
        #1;
        check("reset_mid_line", out_vec(), 64'd0);
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        skip_left = SKIP;
        prev_cap  = 1'b0;
        cur_cap   = 1'b0;
        exp_err   = 1'b0;
        exp_fcnt  = 0;
        exp_q.delete();
        repeat (3) @(negedge clk_pclk);
        obs_q.delete();
        obs_cyc_q.delete();
        rst_100 = 1'b1;
        repeat (10) @(negedge clk_pclk);
        for (int f = 0; f < 3; f++) begin
            fill_full();
            run_frame(1'b1, 1'b0, 1'b0);
        end

        end_pulse();
        check("stray_markers", stray, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
